dtmf_digit_collector: RTL and testbench

Downstream of the tone lookup stage: consumes one 16-bit tone code per analysis frame and turns the noisy per-frame codes into clean, single-shot key-press digits. A key is accepted only after it is stable for a set number of consecutive frames, and reported once per press. It is re-armed only after a confirmed silence gap. Accepted digits are buffered in a small FIFO and drained by the control logic through a valid/ready handshake.

---
 rtl/dtmf_pkg.sv | 38 +++
 rtl/dtmf_digit_fifo.sv | 102 ++++++++++
 rtl/dtmf_digit_collector.sv | 138 +++++++++++++
 tb/tb_dtmf_digit_collector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// Shared DTMF definitions: tone codes from the lookup stage, the digit type
// and the detector state encoding.
package dtmf_pkg;

  localparam logic [15:0] NO_TONE = 16'hFFFF;

  // Key codes produced by the lookup stage.
  localparam logic [15:0] KEY_0  = 16'h0000;
  localparam logic [15:0] KEY_1  = 16'h0001;
  localparam logic [15:0] KEY_2  = 16'h0002;
  localparam logic [15:0] KEY_3  = 16'h0003;
  localparam logic [15:0] KEY_4  = 16'h0004;
  localparam logic [15:0] KEY_5  = 16'h0005;
  localparam logic [15:0] KEY_6  = 16'h0006;
  localparam logic [15:0] KEY_7  = 16'h0007;
  localparam logic [15:0] KEY_8  = 16'h0008;
  localparam logic [15:0] KEY_9  = 16'h0009;
  localparam logic [15:0] KEY_10 = 16'h000A;
  localparam logic [15:0] KEY_11 = 16'h000B;
  localparam logic [15:0] KEY_12 = 16'h000C;
  localparam logic [15:0] KEY_13 = 16'h000D;
  localparam logic [15:0] KEY_14 = 16'h000E;
  localparam logic [15:0] KEY_15 = 16'h000F;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAND   = 2'd1,
    LOCKED = 2'd2
  } det_state_t;

  // Any code above 15 (including NO_TONE) counts as silence.
  function automatic logic is_key(input logic [15:0] code);
    return code[15:4] == 12'h000;
  endfunction

endpackage

// File: rtl/dtmf_digit_fifo.sv
// First-word-fall-through digit FIFO with registered head, count and a
// sticky overflow flag.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   push, push_data    : write request and digit
//   pop_req            : consumer ready; a pop happens only when head_valid
//   head_valid/data    : registered FIFO head
//   count              : entries held
//   overflow           : sticky, set when a push is dropped on a full FIFO
module dtmf_digit_fifo
  import dtmf_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [3:0]             push_data,
  input  logic                   pop_req,
  output logic                   head_valid,
  output logic [3:0]             head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  digit_t          mem_q [DEPTH];
  digit_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            valid_q, valid_d;
  digit_t          head_q, head_d;

  logic            full_c;
  logic            empty_c;
  logic            pop_c;
  logic            push_ok_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == CW'(0));
  assign pop_c     = pop_req & ~empty_c;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_c = push & (~full_c | pop_c);

  // Next-state: storage, pointers, count, and the head register that
  // already reflects this cycle's push/pop.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full_c & ~pop_c);

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push_ok_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok_c && pop_c) begin
      count_d = count_q - CW'(1);
    end

    valid_d = (count_d != CW'(0));
    head_d  = valid_d ? mem_d[rd_ptr_d] : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 4'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= 4'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  assign head_valid = valid_q;
  assign head_data  = head_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/dtmf_digit_collector.sv
// Turns noisy per-frame DTMF tone codes into single-shot key digits: a key
// is accepted after STABLE_FRAMES identical frames, reported once, and
// re-armed only after GAP_FRAMES non-matching frames. Digits are buffered
// in a FWFT FIFO drained through a valid/ready handshake.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   tone_valid, tone     : one frame result per tone_valid pulse
//   digit_valid, digit   : FIFO head, held until digit_ready
//   digit_ready          : consumer accepts the head
//   fifo_count           : entries held
//   overflow             : sticky, a digit was dropped on a full FIFO
module dtmf_digit_collector
  import dtmf_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned GAP_FRAMES    = 2,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tone_valid,
  input  logic [15:0]                 tone,
  output logic                        digit_valid,
  output logic [3:0]                  digit,
  input  logic                        digit_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam logic [3:0] STAB_TGT = 4'(STABLE_FRAMES);
  localparam logic [3:0] GAP_TGT  = 4'(GAP_FRAMES);

  det_state_t state_q, state_d;
  digit_t     cand_q, cand_d;
  logic [3:0] stab_q, stab_d;
  logic [3:0] gap_q, gap_d;

  logic       frame_is_key_c;
  digit_t     frame_key_c;
  logic       push_c;
  digit_t     push_data_c;

  assign frame_is_key_c = is_key(tone);
  assign frame_key_c    = tone[3:0];

  // Detector next-state; only frames (tone_valid) advance it.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    gap_d       = gap_q;
    push_c      = 1'b0;
    push_data_c = cand_q;

    if (tone_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_is_key_c) begin
            cand_d      = frame_key_c;
            stab_d      = 4'd1;
            gap_d       = 4'd0;
            push_data_c = frame_key_c;
            if (STAB_TGT == 4'd1) begin
              push_c  = 1'b1;
              state_d = LOCKED;
            end else begin
              state_d = CAND;
            end
          end
        end

        CAND: begin
          if (!frame_is_key_c) begin
            stab_d  = 4'd0;
            state_d = IDLE;
          end else if (frame_key_c == cand_q) begin
            stab_d = 4'(stab_q + 4'd1);
            if (4'(stab_q + 4'd1) == STAB_TGT) begin
              push_c  = 1'b1;
              gap_d   = 4'd0;
              state_d = LOCKED;
            end
          end else begin
            cand_d = frame_key_c;
            stab_d = 4'd1;
          end
        end

        LOCKED: begin
          // Same key bridges a short dropout; anything else counts toward the gap.
          if (frame_is_key_c && (frame_key_c == cand_q)) begin
            gap_d = 4'd0;
          end else if (4'(gap_q + 4'd1) == GAP_TGT) begin
            gap_d   = 4'd0;
            stab_d  = 4'd0;
            state_d = IDLE;
          end else begin
            gap_d = 4'(gap_q + 4'd1);
          end
        end

        default: begin
          state_d = IDLE;
          stab_d  = 4'd0;
          gap_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      stab_q  <= 4'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
    end
  end

  dtmf_digit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_c),
    .push_data  (push_data_c),
    .pop_req    (digit_ready),
    .head_valid (digit_valid),
    .head_data  (digit),
    .count      (fifo_count),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_dtmf_digit_collector.sv
// Bench for dtmf_digit_collector: expected digits are queued as frames are
// driven and compared as the consumer pops them.
module tb_dtmf_digit_collector;
  import dtmf_pkg::*;

  logic        clock;
  logic        reset;
  logic        tone_valid;
  logic [15:0] tone;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        digit_ready;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  dtmf_digit_collector #(
    .STABLE_FRAMES (3),
    .GAP_FRAMES    (2),
    .FIFO_DEPTH    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tone_valid  (tone_valid),
    .tone        (tone),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One frame per call; inputs change 1ns after the rising edge.
  task automatic drive_frame(input logic [15:0] code, input bit exp_push, input logic [3:0] exp_d);
    tone_valid = 1'b1;
    tone       = code;
    if (exp_push) sb.push_back(exp_d);
    @(posedge clock); #1;
    tone_valid = 1'b0;
    tone       = NO_TONE;
  endtask

  task automatic press(input logic [3:0] k);
    for (int i = 0; i < 3; i++) drive_frame({12'h000, k}, (i == 2), k);
  endtask

  task automatic gap();
    drive_frame(NO_TONE, 1'b0, 4'd0);
    drive_frame(NO_TONE, 1'b0, 4'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Pop everything the DUT presents, comparing against the scoreboard.
  task automatic drain_check(input string name);
    logic [3:0] exp_d;
    idle(2);
    digit_ready = 1'b1;
    for (int n = 0; n < 40 && digit_valid === 1'b1; n++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected digit: got %0d, required none", name, digit);
      end else begin
        exp_d = sb.pop_front();
        if (digit !== exp_d) begin
          errors++;
          $display("FAIL %s digit: got %0d, required %0d", name, digit, exp_d);
        end
      end
      @(posedge clock); #1;
    end
    digit_ready = 1'b0;
    checks++;
    if (sb.size() != 0 || digit_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL %s drain: missing=%0d valid=%b count=%0d, required 0/0/0",
               name, sb.size(), digit_valid, fifo_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", digit_valid); end
    checks++; if (digit !== 4'd0)       begin errors++; $display("FAIL reset_digit: got %0d, required 0", digit); end
    checks++; if (fifo_count !== 4'd0)  begin errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_accept();
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL accept_early: valid=%b, required 0", digit_valid); end
    drive_frame(KEY_5, 1'b1, 4'd5);
    checks++; if (digit_valid !== 1'b1 || digit !== 4'd5)
      begin errors++; $display("FAIL accept_latency: valid=%b digit=%0d, required 1/5", digit_valid, digit); end
    for (int i = 0; i < 4; i++) drive_frame(KEY_5, 1'b0, 4'd0);
    idle(3);
    checks++; if (fifo_count !== 4'd1 || digit_valid !== 1'b1 || digit !== 4'd5)
      begin errors++; $display("FAIL accept_hold: count=%0d valid=%b digit=%0d, required 1/1/5", fifo_count, digit_valid, digit); end
    drain_check("accept");
    gap();
  endtask

  task automatic test_cand_reset();
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(NO_TONE, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    idle(2);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL cand_reset_count: got %0d, required 0", fifo_count); end
    // Candidate already holds one 5, so the second of these frames accepts.
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b1, 4'd5);
    drive_frame(KEY_5, 1'b0, 4'd0);
    drain_check("cand_reset");
    gap();
  endtask

  task automatic test_bridge();
    press(4'd5);
    drive_frame(NO_TONE, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    gap();
    press(4'd5);
    drain_check("bridge");
    gap();
  endtask

  task automatic test_other_key();
    press(4'd5);
    drive_frame(KEY_7, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(KEY_7, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    gap();
    press(4'd7);
    drive_frame(16'h0020, 1'b0, 4'd0);
    drive_frame(16'h0020, 1'b0, 4'd0);
    press(4'd7);
    gap();
    drive_frame(KEY_5, 1'b0, 4'd0);
    drive_frame(16'h0020, 1'b0, 4'd0);
    drive_frame(KEY_5, 1'b0, 4'd0);
    gap();
    drain_check("other_key");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 3; i++) drive_frame(16'(k), (i == 2) && (k < 8), 4'(k));
      gap();
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d, required 8", fifo_count); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    checks++; if (digit_valid !== 1'b1 || digit !== 4'd0)
      begin errors++; $display("FAIL ovf_head: valid=%b digit=%0d, required 1/0", digit_valid, digit); end
    drain_check("overflow");
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] exp_d;
    pulse_reset();
    sb.delete();
    for (int k = 8; k < 16; k++) begin
      press(4'(k));
      gap();
    end
    checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0)
      begin errors++; $display("FAIL full_fill: count=%0d ovf=%b, required 8/0", fifo_count, overflow); end
    drive_frame(KEY_4, 1'b0, 4'd0);
    drive_frame(KEY_4, 1'b0, 4'd0);
    // Accepting frame and a pop share one edge.
    digit_ready = 1'b1;
    checks++;
    exp_d = sb.pop_front();
    if (digit !== exp_d) begin errors++; $display("FAIL full_pop_head: got %0d, required %0d", digit, exp_d); end
    drive_frame(KEY_4, 1'b1, 4'd4);
    digit_ready = 1'b0;
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_simul_count: got %0d, required 8", fifo_count); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL full_simul_ovf: got %b, required 0", overflow); end
    gap();
    drain_check("full_push_pop");
  endtask

  task automatic test_reset_mid_cand();
    press(4'd2);
    gap();
    drive_frame(KEY_3, 1'b0, 4'd0);
    drive_frame(KEY_3, 1'b0, 4'd0);
    pulse_reset();
    sb.delete();
    checks++; if (digit_valid !== 1'b0 || digit !== 4'd0 || fifo_count !== 4'd0 || overflow !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs: valid=%b digit=%0d count=%0d ovf=%b, required all 0",
                               digit_valid, digit, fifo_count, overflow); end
    drive_frame(KEY_3, 1'b0, 4'd0);
    idle(2);
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL midreset_progress: count=%0d, required 0", fifo_count); end
    drive_frame(KEY_3, 1'b0, 4'd0);
    drive_frame(KEY_3, 1'b1, 4'd3);
    checks++; if (fifo_count !== 4'd1 || digit !== 4'd3)
      begin errors++; $display("FAIL midreset_accept: count=%0d digit=%0d, required 1/3", fifo_count, digit); end
    drain_check("mid_reset");
  endtask

  initial begin
    reset       = 1'b1;
    tone_valid  = 1'b0;
    tone        = NO_TONE;
    digit_ready = 1'b0;
    test_reset();
    test_accept();
    test_cand_reset();
    test_bridge();
    test_other_key();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_cand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
